pc_npc_unit: RTL and testbench

- Parametrised PC/nPC pair for the MIPS pipeline fetch stage; successor to the single-register PC.
- Holds the current PC and next PC, and supports stalls, branches with one architectural delay slot, exception redirect with EPC capture, and halt/resume.
- Sits between the fetch-stage PC source logic and instruction memory; pc_out addresses instruction memory.

---
 rtl/pc_npc_unit_pkg.sv | 15 +
 rtl/pc_npc_unit_if.sv | 28 ++
 rtl/pc_npc_unit.sv | 88 ++++++++
 tb/tb_pc_npc_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pc_npc_unit_pkg.sv
// Shared types and default constants for the fetch-stage PC/nPC unit.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_RUN   = 2'd0,
    PC_DELAY = 2'd1,
    PC_HALT  = 2'd2
  } pc_state_e;

  localparam int unsigned PC_WIDTH_DEF      = 9;
  localparam int unsigned PC_INC_DEF        = 4;
  localparam int unsigned PC_RESET_DEF      = 0;
  localparam int unsigned PC_EXC_VECTOR_DEF = 'h180;

endpackage

// File: rtl/pc_npc_unit_if.sv
// Fetch-control bus between the PC source logic (master) and the PC/nPC unit (slave).
interface pc_npc_unit_if #(
  parameter int unsigned WIDTH = pc_pkg::PC_WIDTH_DEF
);
  logic             le;
  logic             branch_taken;
  logic [WIDTH-1:0] target;
  logic             exc_req;
  logic             halt_req;
  logic             resume;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] npc_out;
  logic [WIDTH-1:0] epc_out;
  logic             in_delay_slot;
  logic             exc_bd;
  logic             halted;
  logic             nested_branch;

  modport master (
    output le, branch_taken, target, exc_req, halt_req, resume,
    input  pc_out, npc_out, epc_out, in_delay_slot, exc_bd, halted, nested_branch
  );

  modport slave (
    input  le, branch_taken, target, exc_req, halt_req, resume,
    output pc_out, npc_out, epc_out, in_delay_slot, exc_bd, halted, nested_branch
  );
endinterface

// File: rtl/pc_npc_unit.sv
// PC/nPC pair with one branch delay slot, exception redirect with EPC capture,
// and halt/resume. All outputs come straight from registers.
module pc_npc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = PC_WIDTH_DEF,
  parameter int unsigned      INC        = PC_INC_DEF,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(PC_RESET_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(PC_EXC_VECTOR_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  pc_npc_unit_if.slave       bus
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] npc_q, npc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             exc_bd_q, exc_bd_d;
  logic             nested_q, nested_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    epc_d    = epc_q;
    exc_bd_d = exc_bd_q;
    nested_d = 1'b0;

    if (bus.exc_req) begin
      pc_d    = EXC_VECTOR;
      npc_d   = EXC_VECTOR + INC_W;
      state_d = PC_RUN;
      // In a delay slot the restart point is the branch itself, one slot back.
      if (state_q == PC_DELAY) begin
        epc_d    = pc_q - INC_W;
        exc_bd_d = 1'b1;
      end else begin
        epc_d    = pc_q;
        exc_bd_d = 1'b0;
      end
    end else if (state_q == PC_HALT) begin
      if (bus.resume) state_d = PC_RUN;
    end else if (bus.halt_req) begin
      state_d = PC_HALT;
    end else if (bus.le) begin
      pc_d = npc_q;
      if (bus.branch_taken && state_q == PC_RUN) begin
        npc_d   = bus.target;
        state_d = PC_DELAY;
      end else begin
        npc_d    = npc_q + INC_W;
        state_d  = PC_RUN;
        nested_d = bus.branch_taken;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= PC_RUN;
      pc_q     <= RESET_PC;
      npc_q    <= RESET_PC + INC_W;
      epc_q    <= '0;
      exc_bd_q <= 1'b0;
      nested_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      epc_q    <= epc_d;
      exc_bd_q <= exc_bd_d;
      nested_q <= nested_d;
    end
  end

  assign bus.pc_out        = pc_q;
  assign bus.npc_out       = npc_q;
  assign bus.epc_out       = epc_q;
  assign bus.in_delay_slot = (state_q == PC_DELAY);
  assign bus.halted        = (state_q == PC_HALT);
  assign bus.exc_bd        = exc_bd_q;
  assign bus.nested_branch = nested_q;

endmodule

// File: tb/tb_pc_npc_unit.sv
// Vector-table bench for pc_npc_unit with a scoreboard queue of expected outputs.
module tb_pc_npc_unit;

  localparam int unsigned W = 9;

  typedef struct {
    logic         rst_n;
    logic         le;
    logic         br;
    logic [W-1:0] tgt;
    logic         exc;
    logic         halt;
    logic         res;
    logic [W-1:0] pc;
    logic [W-1:0] npc;
    logic [W-1:0] epc;
    logic         ds;
    logic         bd;
    logic         hlt;
    logic         nst;
  } vec_t;

  typedef struct {
    int           idx;
    logic [W-1:0] pc;
    logic [W-1:0] npc;
    logic [W-1:0] epc;
    logic         ds;
    logic         bd;
    logic         hlt;
    logic         nst;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_npc_unit_if #(.WIDTH(W)) bus ();

  pc_npc_unit #(
    .WIDTH     (W),
    .INC       (4),
    .RESET_PC  (9'h000),
    .EXC_VECTOR(9'h180)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  task automatic add(input logic r, input logic le, input logic br, input logic [W-1:0] tgt,
                     input logic exc, input logic halt, input logic res,
                     input logic [W-1:0] pc, input logic [W-1:0] npc, input logic [W-1:0] epc,
                     input logic ds, input logic bd, input logic hlt, input logic nst);
    vec_t v;
    v.rst_n = r; v.le = le; v.br = br; v.tgt = tgt; v.exc = exc; v.halt = halt; v.res = res;
    v.pc = pc; v.npc = npc; v.epc = epc; v.ds = ds; v.bd = bd; v.hlt = hlt; v.nst = nst;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    exp_t e;
    //   rst le br tgt    ex hl rs  pc     npc    epc    ds bd hl ns
    // reset held two cycles, then sequential fetch
    add(0, 1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h004, 9'h000, 0, 0, 0, 0); // 0
    add(0, 1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h004, 9'h000, 0, 0, 0, 0);
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h004, 9'h008, 9'h000, 0, 0, 0, 0);
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h008, 9'h00C, 9'h000, 0, 0, 0, 0);
    // branch at 8 to 0x40: delay slot 12, then target
    add(1, 1, 1, 9'h040, 0, 0, 0, 9'h00C, 9'h040, 9'h000, 1, 0, 0, 0); // 4
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h040, 9'h044, 9'h000, 0, 0, 0, 0);
    // back to pc=12 in DELAY, stall 3 cycles, then ignored nested branch
    add(0, 1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h004, 9'h000, 0, 0, 0, 0);
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h004, 9'h008, 9'h000, 0, 0, 0, 0);
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h008, 9'h00C, 9'h000, 0, 0, 0, 0);
    add(1, 1, 1, 9'h040, 0, 0, 0, 9'h00C, 9'h040, 9'h000, 1, 0, 0, 0);
    add(1, 0, 0, 9'h000, 0, 0, 0, 9'h00C, 9'h040, 9'h000, 1, 0, 0, 0); // 10
    add(1, 0, 1, 9'h0F0, 0, 0, 0, 9'h00C, 9'h040, 9'h000, 1, 0, 0, 0);
    add(1, 0, 0, 9'h000, 0, 0, 0, 9'h00C, 9'h040, 9'h000, 1, 0, 0, 0);
    add(1, 1, 1, 9'h080, 0, 0, 0, 9'h040, 9'h044, 9'h000, 0, 0, 0, 1);
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h044, 9'h048, 9'h000, 0, 0, 0, 0);
    // exception in delay slot at 12 (le low: exception ignores stall)
    add(0, 1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h004, 9'h000, 0, 0, 0, 0); // 15
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h004, 9'h008, 9'h000, 0, 0, 0, 0);
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h008, 9'h00C, 9'h000, 0, 0, 0, 0);
    add(1, 1, 1, 9'h040, 0, 0, 0, 9'h00C, 9'h040, 9'h000, 1, 0, 0, 0);
    add(1, 0, 0, 9'h000, 1, 0, 0, 9'h180, 9'h184, 9'h008, 0, 1, 0, 0);
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h184, 9'h188, 9'h008, 0, 1, 0, 0); // 20
    // exception from RUN at 0x20
    add(1, 1, 1, 9'h020, 0, 0, 0, 9'h188, 9'h020, 9'h008, 1, 1, 0, 0);
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h020, 9'h024, 9'h008, 0, 1, 0, 0);
    add(1, 1, 0, 9'h000, 1, 0, 0, 9'h180, 9'h184, 9'h020, 0, 0, 0, 0);
    // reach 0x1FC, npc wraps to 0, halt 6 cycles, resume with halt_req also high
    add(1, 1, 1, 9'h1FC, 0, 0, 0, 9'h184, 9'h1FC, 9'h020, 1, 0, 0, 0);
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h1FC, 9'h000, 9'h020, 0, 0, 0, 0); // 25
    add(1, 1, 0, 9'h000, 0, 1, 0, 9'h1FC, 9'h000, 9'h020, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++)
      add(1, 1, (i == 2), 9'h0A0, 0, (i == 3), 0, 9'h1FC, 9'h000, 9'h020, 0, 0, 1, 0);
    add(1, 1, 0, 9'h000, 0, 1, 1, 9'h1FC, 9'h000, 9'h020, 0, 0, 0, 0);
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h004, 9'h020, 0, 0, 0, 0);
    // halt from DELAY keeps the pending target in npc
    add(1, 1, 1, 9'h100, 0, 0, 0, 9'h004, 9'h100, 9'h020, 1, 0, 0, 0);
    add(1, 1, 0, 9'h000, 0, 1, 0, 9'h004, 9'h100, 9'h020, 0, 0, 1, 0); // 35
    add(1, 0, 0, 9'h000, 0, 0, 1, 9'h004, 9'h100, 9'h020, 0, 0, 0, 0);
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h100, 9'h104, 9'h020, 0, 0, 0, 0);
    // exception during HALT exits HALT
    add(1, 1, 0, 9'h000, 0, 1, 0, 9'h100, 9'h104, 9'h020, 0, 0, 1, 0);
    add(1, 1, 0, 9'h000, 1, 0, 0, 9'h180, 9'h184, 9'h100, 0, 0, 0, 0);
    // reset mid-DELAY
    add(1, 1, 1, 9'h060, 0, 0, 0, 9'h184, 9'h060, 9'h100, 1, 0, 0, 0); // 40
    add(0, 1, 1, 9'h070, 0, 0, 0, 9'h000, 9'h004, 9'h000, 0, 0, 0, 0);
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h004, 9'h008, 9'h000, 0, 0, 0, 0);
    // exc_bd set, then halt, then reset mid-HALT clears everything
    add(1, 1, 1, 9'h040, 0, 0, 0, 9'h008, 9'h040, 9'h000, 1, 0, 0, 0);
    add(1, 1, 0, 9'h000, 1, 0, 0, 9'h180, 9'h184, 9'h004, 0, 1, 0, 0);
    add(1, 1, 0, 9'h000, 0, 1, 0, 9'h180, 9'h184, 9'h004, 0, 1, 1, 0); // 45
    add(0, 1, 0, 9'h000, 0, 1, 0, 9'h000, 9'h004, 9'h000, 0, 0, 0, 0);
    add(1, 1, 0, 9'h000, 0, 0, 0, 9'h004, 9'h008, 9'h000, 0, 0, 0, 0);

    rst_n = 1'b0;
    bus.le = 1'b0; bus.branch_taken = 1'b0; bus.target = '0;
    bus.exc_req = 1'b0; bus.halt_req = 1'b0; bus.resume = 1'b0;

    foreach (tbl[k]) begin
      @(negedge clk);
      rst_n            = tbl[k].rst_n;
      bus.le           = tbl[k].le;
      bus.branch_taken = tbl[k].br;
      bus.target       = tbl[k].tgt;
      bus.exc_req      = tbl[k].exc;
      bus.halt_req     = tbl[k].halt;
      bus.resume       = tbl[k].res;
      e.idx = k; e.pc = tbl[k].pc; e.npc = tbl[k].npc; e.epc = tbl[k].epc;
      e.ds = tbl[k].ds; e.bd = tbl[k].bd; e.hlt = tbl[k].hlt; e.nst = tbl[k].nst;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard step %0d: got empty queue expected entry", k);
      end else begin
        e = sb.pop_front();
        chk("pc_out",        e.idx, bus.pc_out,  e.pc);
        chk("npc_out",       e.idx, bus.npc_out, e.npc);
        chk("epc_out",       e.idx, bus.epc_out, e.epc);
        chk("in_delay_slot", e.idx, W'(bus.in_delay_slot), W'(e.ds));
        chk("exc_bd",        e.idx, W'(bus.exc_bd),        W'(e.bd));
        chk("halted",        e.idx, W'(bus.halted),        W'(e.hlt));
        chk("nested_branch", e.idx, W'(bus.nested_branch), W'(e.nst));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
